pulse_width_monitor: RTL and testbench

PULSE_WIDTH_MONITOR -- requirements
Module: pulse_width_monitor

---
 rtl/pulse_width_monitor_pkg.sv | 8 +
 rtl/pulse_width_monitor_sync_ff.sv | 20 ++
 rtl/pulse_width_monitor.sv | 120 ++++++++++++
 tb/tb_pulse_width_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_monitor_pkg.sv
// Shared types and default sizing for the pulse width monitor.
package delay_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_PEND} state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MIN_WIDTH   = 3;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/pulse_width_monitor_sync_ff.sv
// Multi-stage flip-flop synchronizer bringing an asynchronous input into clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pulse_width_monitor.sv
// Measures run lengths of a synchronized input, reports them over a valid/ready
// handshake and produces an inertially filtered copy of the input.
module pulse_width_monitor
  import delay_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic             filt_o,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_level,
  output logic             meas_glitch,
  output logic             ovf,
  input  logic             ovf_clr
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

  logic             s;
  logic             s_prev_q, s_prev_d;
  logic             edge_det;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             filt_q, filt_d;
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             level_q, level_d;
  logic             glitch_q, glitch_d;
  logic             ovf_q, ovf_d;
  logic             capture, ovf_set;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (s)
  );

  always_comb begin
    s_prev_d  = s;
    edge_det  = s ^ s_prev_q;
    if (edge_det)                run_cnt_d = CNT_W'(1);
    else if (run_cnt_q == CNT_MAX) run_cnt_d = run_cnt_q;
    else                         run_cnt_d = run_cnt_q + CNT_W'(1);
    // The filter commits once the current run has lasted MIN_WIDTH cycles.
    filt_d = (run_cnt_d == MIN_W) ? s : filt_q;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    capture = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_det) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (edge_det) begin
          capture = 1'b1;
          valid_d = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (meas_ready) begin
          if (edge_det) capture = 1'b1;
          else begin
            valid_d = 1'b0;
            state_d = ST_MEASURE;
          end
        end else if (edge_det) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    width_d  = capture ? run_cnt_q : width_q;
    level_d  = capture ? s_prev_q : level_q;
    glitch_d = capture ? (run_cnt_q < MIN_W) : glitch_q;
    ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_prev_q  <= 1'b0;
      run_cnt_q <= '0;
      filt_q    <= 1'b0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      width_q   <= '0;
      level_q   <= 1'b0;
      glitch_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s_prev_q  <= s_prev_d;
      run_cnt_q <= run_cnt_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      width_q   <= width_d;
      level_q   <= level_d;
      glitch_q  <= glitch_d;
      ovf_q     <= ovf_d;
    end
  end

  assign filt_o      = filt_q;
  assign meas_valid  = valid_q;
  assign meas_width  = width_q;
  assign meas_level  = level_q;
  assign meas_glitch = glitch_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor with MIN_WIDTH=3, SYNC_STAGES=2, CNT_W=8.
module tb_pulse_width_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       meas_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       filt_o, meas_valid, meas_level, meas_glitch, ovf;
  logic [7:0] meas_width;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {logic [7:0] w; logic l; logic g;} rpt_t;
  rpt_t rq[$];

  pulse_width_monitor #(.CNT_W(8), .MIN_WIDTH(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .filt_o(filt_o),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_width(meas_width),
    .meas_level(meas_level), .meas_glitch(meas_glitch), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Handshakes are recorded at the falling edge preceding the accepting rising edge.
  always @(negedge clk)
    if (rst_n && meas_valid && meas_ready) rq.push_back({meas_width, meas_level, meas_glitch});

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a = 1'b0; meas_ready = 1'b1; ovf_clr = 1'b0;
    step(3);
    n_cmp++;
    if ({filt_o, meas_valid, meas_width, meas_level, meas_glitch, ovf} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0",
               {filt_o, meas_valid, meas_width, meas_level, meas_glitch, ovf});
    end
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_basic;
    logic exp_f;
    rpt_t exp_r[4];
    exp_r[0] = {8'd5, 1'b1, 1'b0};
    exp_r[1] = {8'd2, 1'b0, 1'b1};
    exp_r[2] = {8'd1, 1'b1, 1'b1};
    exp_r[3] = {8'd5, 1'b0, 1'b0};
    rq.delete();
    for (int n = 1; n <= 24; n++) begin
      if (n <= 5) a = 1'b1;
      else if (n <= 7) a = 1'b0;
      else if (n == 8) a = 1'b1;
      else if (n <= 13) a = 1'b0;
      else a = 1'b1;
      step();
      exp_f = (n >= 5 && n <= 12) || (n >= 18);
      n_cmp++;
      if (filt_o !== exp_f) begin
        n_bad++;
        $display("FAIL filt_step%0d: got %b required %b", n, filt_o, exp_f);
      end
    end
    n_cmp++;
    if (rq.size() != 4) begin
      n_bad++;
      $display("FAIL basic_count: got %0d required 4", rq.size());
    end
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL basic_rpt%0d: got w=%0d l=%b g=%b required w=%0d l=%b g=%b", i,
                 rq[i].w, rq[i].l, rq[i].g, exp_r[i].w, exp_r[i].l, exp_r[i].g);
      end
    end
  endtask

  task automatic test_latency;
    logic exp_v;
    a = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      exp_v = (n == 3);
      n_cmp++;
      if (meas_valid !== exp_v) begin
        n_bad++;
        $display("FAIL latency_step%0d: got %b required %b", n, meas_valid, exp_v);
      end
    end
    step(2);
  endtask

  task automatic test_saturation;
    rq.delete();
    step(300);
    a = 1'b1;
    step(5);
    n_cmp++;
    if (rq.size() != 1 || rq[0] !== {8'd255, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL saturation: got n=%0d w=%0d l=%b g=%b required n=1 w=255 l=0 g=0",
               rq.size(), rq.size() > 0 ? rq[0].w : 8'd0,
               rq.size() > 0 ? rq[0].l : 1'b0, rq.size() > 0 ? rq[0].g : 1'b0);
    end
  endtask

  task automatic test_overflow;
    a = 1'b0;
    step(6);
    meas_ready = 1'b0;
    a = 1'b1;
    step(4);
    n_cmp++;
    if ({meas_valid, meas_width, ovf} !== {1'b1, 8'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_first: got v=%b w=%0d ovf=%b required v=1 w=6 ovf=0",
               meas_valid, meas_width, ovf);
    end
    a = 1'b0;
    step(4);
    a = 1'b1;
    step(4);
    n_cmp++;
    if ({meas_valid, meas_width, meas_level, meas_glitch, ovf} !== {1'b1, 8'd6, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_held: got v=%b w=%0d l=%b g=%b ovf=%b required v=1 w=6 l=0 g=0 ovf=1",
               meas_valid, meas_width, meas_level, meas_glitch, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++;
    if ({ovf, meas_valid, meas_width} !== {1'b0, 1'b1, 8'd6}) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b v=%b w=%0d required ovf=0 v=1 w=6", ovf, meas_valid, meas_width);
    end
  endtask

  task automatic test_set_wins;
    a = 1'b0;
    step(2);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set_wins: got %b required 1", ovf);
    end
    step(3);
    n_cmp++;
    if (meas_width !== 8'd6) begin
      n_bad++;
      $display("FAIL ovf_hold_after: got w=%0d required 6", meas_width);
    end
    meas_ready = 1'b1;
    step(2);
    n_cmp++;
    if (meas_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_valid: got %b required 0", meas_valid);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    rq.delete();
    for (int i = 0; i < 8; i++) begin
      a = ~a;
      step();
    end
    step(6);
    n_cmp++;
    if (rq.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d required 8", rq.size());
    end
    for (int i = 1; i < 8 && i < rq.size(); i++) begin
      n_cmp++;
      if (rq[i].w !== 8'd1 || rq[i].g !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_rpt%0d: got w=%0d g=%b required w=1 g=1", i, rq[i].w, rq[i].g);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ovf: got %b required 0", ovf);
    end
  endtask

  task automatic test_reset_pend;
    meas_ready = 1'b0;
    a = 1'b1;
    step(5);
    n_cmp++;
    if (meas_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_before_reset: got %b required 1", meas_valid);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({filt_o, meas_valid, meas_width, meas_level, meas_glitch, ovf} !== 13'd0) begin
      n_bad++;
      $display("FAIL pend_reset_outputs: got %b required 0",
               {filt_o, meas_valid, meas_width, meas_level, meas_glitch, ovf});
    end
    rst_n = 1'b1;
    meas_ready = 1'b1;
    rq.delete();
    step(4);
    n_cmp++;
    if (meas_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_first_edge: got %b required 0", meas_valid);
    end
    step(3);
    a = 1'b0;
    step(7);
    n_cmp++;
    if (rq.size() != 1 || rq[0] !== {8'd7, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_run: got n=%0d w=%0d required n=1 w=7 l=1 g=0",
               rq.size(), rq.size() > 0 ? rq[0].w : 8'd0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_saturation();
    test_overflow();
    test_set_wins();
    test_back_to_back();
    test_reset_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
